// File: rtl/rebotin_pkg.sv
// Shared types for the LED bouncer pattern decoder: FSM state encoding and error codes.
package rebotin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_NOT_ONEHOT = 2'b01;
  localparam logic [1:0] ERR_BAD_STEP   = 2'b10;
  localparam logic [1:0] ERR_STALL      = 2'b11;

endpackage

// File: rtl/rebotin_onehot_enc.sv
// Combinational one-hot check and bit-index encoder for the observed LED pattern.
module rebotin_onehot_enc #(
  parameter int  WIDTH = 8,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  output logic             is_onehot,
  output logic [IW-1:0]    idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (q[i]) idx = idx | IW'(i);
    end
    is_onehot = (q != '0) && ((q & (q - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/rebotin_decoder.sv
// Decodes the bouncing one-hot LED pattern into position, direction, sweep status and errors.
// Defining REBOTIN_DEC_SYNC_EN inserts a 2-flop input synchronizer (latency 1 -> 3 cycles).
// state | meaning
// IDLE  | waiting for the first one-hot pattern
// TRACK | locked; every pattern change must be the next bounce step
// ERROR | bad pattern, bad move or stall; a change to one-hot relocks
module rebotin_decoder
  import rebotin_pkg::*;
#(
  parameter int  WIDTH          = 8,
  parameter int  TIMEOUT_CYCLES = 20000000,
  parameter int  SWEEP_CNT_W    = 16,
  localparam int IW             = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       q_in,
  output logic [IW-1:0]          pos,
  output logic                   pos_valid,
  output logic                   dir,
  output logic                   step,
  output logic                   sweep_done,
  output logic [SWEEP_CNT_W-1:0] sweep_count,
  output logic                   err,
  output logic [1:0]             err_code
);

  localparam int                CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  STALL_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0]     TOP_IDX    = IW'(WIDTH - 1);

  logic [WIDTH-1:0] q_s;

`ifdef REBOTIN_DEC_SYNC_EN
  logic [WIDTH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= q_in;
      sync2_q <= sync1_q;
    end
  end
  assign q_s = sync2_q;
`else
  assign q_s = q_in;
`endif

  logic                   is_onehot;
  logic [IW-1:0]          idx;

  rebotin_onehot_enc #(.WIDTH(WIDTH)) u_enc (
    .q         (q_s),
    .is_onehot (is_onehot),
    .idx       (idx)
  );

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       q_prev_q;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic [IW-1:0]          pos_q, pos_d;
  logic                   pos_valid_q, pos_valid_d;
  logic                   dir_q, dir_d;
  logic                   step_q, step_d;
  logic                   sweep_done_q, sweep_done_d;
  logic [SWEEP_CNT_W-1:0] sweep_count_q, sweep_count_d;
  logic                   err_q, err_d;
  logic [1:0]             err_code_q, err_code_d;
  logic                   change, relock;
  logic [1:0]             fault;
  logic [WIDTH-1:0]       expected;

  assign change = (q_s != q_prev_q);

  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    pos_valid_d   = pos_valid_q;
    dir_d         = dir_q;
    step_d        = 1'b0;
    sweep_done_d  = 1'b0;
    sweep_count_d = sweep_count_q;
    err_d         = err_q;
    err_code_d    = err_code_q;
    stall_cnt_d   = '0;
    relock        = 1'b0;
    fault         = ERR_NONE;
    expected      = dir_q ? (q_prev_q << 1) : (q_prev_q >> 1);

    case (state_q)
      ST_IDLE:  relock = is_onehot;
      ST_ERROR: relock = change && is_onehot;
      ST_TRACK: begin
        // a change always wins over a stall expiring on the same edge
        if (change) begin
          if (!is_onehot) begin
            fault = ERR_NOT_ONEHOT;
          end else if (q_s != expected) begin
            fault = ERR_BAD_STEP;
          end else begin
            pos_d  = idx;
            step_d = 1'b1;
            if (idx == TOP_IDX || idx == '0) begin
              sweep_done_d = 1'b1;
              dir_d        = (idx == '0);
              if (sweep_count_q != '1) sweep_count_d = sweep_count_q + SWEEP_CNT_W'(1);
            end
          end
        end else if (TIMEOUT_CYCLES > 0) begin
          if (stall_cnt_q == STALL_LAST) fault = ERR_STALL;
          else                           stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (relock) begin
      state_d     = ST_TRACK;
      pos_d       = idx;
      pos_valid_d = 1'b1;
      dir_d       = (idx != TOP_IDX);
      err_d       = 1'b0;
      err_code_d  = ERR_NONE;
    end
    if (fault != ERR_NONE) begin
      state_d     = ST_ERROR;
      pos_valid_d = 1'b0;
      err_d       = 1'b1;
      err_code_d  = fault;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      q_prev_q      <= '0;
      stall_cnt_q   <= '0;
      pos_q         <= '0;
      pos_valid_q   <= 1'b0;
      dir_q         <= 1'b0;
      step_q        <= 1'b0;
      sweep_done_q  <= 1'b0;
      sweep_count_q <= '0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      q_prev_q      <= q_s;
      stall_cnt_q   <= stall_cnt_d;
      pos_q         <= pos_d;
      pos_valid_q   <= pos_valid_d;
      dir_q         <= dir_d;
      step_q        <= step_d;
      sweep_done_q  <= sweep_done_d;
      sweep_count_q <= sweep_count_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign pos         = pos_q;
  assign pos_valid   = pos_valid_q;
  assign dir         = dir_q;
  assign step        = step_q;
  assign sweep_done  = sweep_done_q;
  assign sweep_count = sweep_count_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule
